// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared widths and source encoding for the register-file
// write-back front end.
package reg_writeback_arbiter_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int BUS_MSB        = DEF_DATA_W - 1;
   localparam int RF_MSB         = DEF_ADDR_W - 1;
   localparam int REG_COUNT      = 1 << DEF_ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_LD  = 1'b1
   } src_e;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Producer handshakes, issue tap and register-file write port
// of the write-back arbiter.
interface reg_writeback_arbiter_if
   import reg_writeback_arbiter_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic                    i_AluValid;
   logic [ADDR_W-1:0]       i_AluAddr;
   logic [DATA_W-1:0]       i_AluData;
   logic                    o_AluReady;
   logic                    i_LdValid;
   logic [ADDR_W-1:0]       i_LdAddr;
   logic [DATA_W-1:0]       i_LdData;
   logic                    o_LdReady;
   logic                    i_IssueValid;
   logic [ADDR_W-1:0]       i_IssueAddr;
   logic                    o_WrEnable;
   logic [ADDR_W-1:0]       o_WrAddr;
   logic [DATA_W-1:0]       o_WrData;
   logic [(2**ADDR_W)-1:0]  o_Pending;
   logic                    o_Idle;

   modport master (
      output i_AluValid, i_AluAddr, i_AluData,
      output i_LdValid, i_LdAddr, i_LdData,
      output i_IssueValid, i_IssueAddr,
      input  o_AluReady, o_LdReady,
      input  o_WrEnable, o_WrAddr, o_WrData,
      input  o_Pending, o_Idle
   );

   modport slave (
      input  i_AluValid, i_AluAddr, i_AluData,
      input  i_LdValid, i_LdAddr, i_LdData,
      input  i_IssueValid, i_IssueAddr,
      output o_AluReady, o_LdReady,
      output o_WrEnable, o_WrAddr, o_WrData,
      output o_Pending, o_Idle
   );

endinterface

// File: rtl/reg_writeback_arbiter_wb_fifo.sv
// Circular-buffer sync FIFO holding {addr, data} write-back
// entries; pointers carry an extra wrap bit.
module wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 4
)(
   input  logic                       i_Clk,
   input  logic                       i_Rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_head,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]  wptr, rptr;
   logic [W-1:0] mem [DEPTH];
   logic         full, do_push, do_pop;

   assign full    = (wptr[PW] != rptr[PW]) &&
                    (wptr[PW-1:0] == rptr[PW-1:0]);
   assign o_empty = (wptr == rptr);
   assign do_push = i_push && !full;
   assign do_pop  = i_pop && !o_empty;
   assign o_head  = mem[rptr[PW-1:0]];
   assign o_count = wptr - rptr;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // storage needs no reset: empty pointers hide stale entries
   always_ff @(posedge i_Clk) begin
      if (do_push) mem[wptr[PW-1:0]] <= i_data;
   end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges ALU and load results into the single register-file
// write port and tracks registers with writes still in flight.
module reg_writeback_arbiter
   import reg_writeback_arbiter_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
)(
   input logic                     i_Clk,
   input logic                     i_Rst_n,
   reg_writeback_arbiter_if.slave  bus
);

   localparam int ENT_W = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int NREG  = 2 ** ADDR_W;

   logic [ENT_W-1:0]  alu_head, ld_head, gnt_entry;
   logic [CNT_W-1:0]  alu_count, ld_count;
   logic              alu_empty, ld_empty;
   logic              gnt_alu, gnt_ld, gnt_any;
   logic [ADDR_W-1:0] gnt_addr;
   src_e              last_src;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [NREG-1:0]   pend_q, pend_nxt;

   wb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_push  (bus.i_AluValid),
      .i_data  ({bus.i_AluAddr, bus.i_AluData}),
      .i_pop   (gnt_alu),
      .o_head  (alu_head),
      .o_empty (alu_empty),
      .o_count (alu_count)
   );

   wb_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_push  (bus.i_LdValid),
      .i_data  ({bus.i_LdAddr, bus.i_LdData}),
      .i_pop   (gnt_ld),
      .o_head  (ld_head),
      .o_empty (ld_empty),
      .o_count (ld_count)
   );

   assign bus.o_AluReady = alu_count < CNT_W'(FIFO_DEPTH);
   assign bus.o_LdReady  = ld_count < CNT_W'(FIFO_DEPTH);

   // contention goes to whichever source lost the last grant
   always_comb begin
      gnt_alu = 1'b0;
      gnt_ld  = 1'b0;
      unique case ({~alu_empty, ~ld_empty})
         2'b11: begin
            gnt_alu = (last_src == SRC_LD);
            gnt_ld  = (last_src == SRC_ALU);
         end
         2'b10: gnt_alu = 1'b1;
         2'b01: gnt_ld  = 1'b1;
         default: ;
      endcase
   end

   assign gnt_any   = gnt_alu | gnt_ld;
   assign gnt_entry = gnt_ld ? ld_head : alu_head;
   assign gnt_addr  = gnt_entry[ENT_W-1:DATA_W];

   // a new issue outranks a commit to the same register
   always_comb begin
      pend_nxt = pend_q;
      if (gnt_any) pend_nxt[gnt_addr] = 1'b0;
      if (bus.i_IssueValid) pend_nxt[bus.i_IssueAddr] = 1'b1;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         last_src  <= SRC_LD;
         pend_q    <= '0;
      end else begin
         wr_en_q <= gnt_any;
         pend_q  <= pend_nxt;
         if (gnt_any) begin
            wr_addr_q <= gnt_addr;
            wr_data_q <= gnt_entry[DATA_W-1:0];
            last_src  <= gnt_ld ? SRC_LD : SRC_ALU;
         end
      end
   end

   assign bus.o_WrEnable = wr_en_q;
   assign bus.o_WrAddr   = wr_addr_q;
   assign bus.o_WrData   = wr_data_q;
   assign bus.o_Pending  = pend_q;
   assign bus.o_Idle     = alu_empty & ld_empty & ~wr_en_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench: queue-based reference model of the two
// source FIFOs, round-robin commit and pending scoreboard.
module tb_reg_writeback_arbiter;
   import reg_writeback_arbiter_pkg::*;

   localparam int DEPTH = DEF_FIFO_DEPTH;
   localparam int EW    = DEF_ADDR_W + DEF_DATA_W;

   typedef logic [EW-1:0] ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   reg_writeback_arbiter_if bus ();

   reg_writeback_arbiter dut (
      .i_Clk   (clk),
      .i_Rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   ent_t                 m_alu[$];
   ent_t                 m_ld[$];
   bit                   m_last_ld;
   logic                 exp_we;
   logic [RF_MSB:0]      exp_addr;
   logic [BUS_MSB:0]     exp_data;
   logic [REG_COUNT-1:0] exp_pend;
   bit                   acc_alu, acc_ld;
   int                   ld_low;

   task automatic model_reset();
      m_alu.delete();
      m_ld.delete();
      m_last_ld = 1'b1;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
      exp_pend  = '0;
      acc_alu   = 1'b0;
      acc_ld    = 1'b0;
   endtask

   function automatic logic exp_idle();
      return (m_alu.size() == 0) && (m_ld.size() == 0) && !exp_we;
   endfunction

   // one rising edge; model decides grant on pre-edge queue contents
   task automatic tick();
      ent_t e, ae, le;
      bit gv, aa, la, iv;
      logic [RF_MSB:0] ia;
      aa = bus.i_AluValid && (m_alu.size() < DEPTH);
      la = bus.i_LdValid && (m_ld.size() < DEPTH);
      ae = {bus.i_AluAddr, bus.i_AluData};
      le = {bus.i_LdAddr, bus.i_LdData};
      iv = bus.i_IssueValid;
      ia = bus.i_IssueAddr;
      gv = 1'b0;
      e  = '0;
      if (m_alu.size() != 0 && (m_ld.size() == 0 || m_last_ld)) begin
         e = m_alu.pop_front(); gv = 1'b1; m_last_ld = 1'b0;
      end else if (m_ld.size() != 0) begin
         e = m_ld.pop_front(); gv = 1'b1; m_last_ld = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_we = gv;
      if (gv) begin
         exp_addr = e[EW-1:DEF_DATA_W];
         exp_data = e[BUS_MSB:0];
         exp_pend[e[EW-1:DEF_DATA_W]] = 1'b0;
      end
      if (iv) exp_pend[ia] = 1'b1;
      if (aa) m_alu.push_back(ae);
      if (la) m_ld.push_back(le);
      acc_alu = aa;
      acc_ld  = la;
   endtask

   task automatic drive_idle();
      bus.i_AluValid   = 1'b0;
      bus.i_LdValid    = 1'b0;
      bus.i_IssueValid = 1'b0;
   endtask

   task automatic run_traffic(input int n, input int ap, input int lp,
                              input int ip, input string tag);
      logic er;
      for (int c = 0; c < n; c++) begin
         if (!(bus.i_AluValid && !acc_alu)) begin
            bus.i_AluValid = int'($urandom_range(99)) < ap;
            bus.i_AluAddr  = 5'($urandom);
            bus.i_AluData  = $urandom;
         end
         if (!(bus.i_LdValid && !acc_ld)) begin
            bus.i_LdValid = int'($urandom_range(99)) < lp;
            bus.i_LdAddr  = 5'($urandom);
            bus.i_LdData  = $urandom;
         end
         bus.i_IssueValid = int'($urandom_range(99)) < ip;
         bus.i_IssueAddr  = 5'($urandom);
         er = m_alu.size() < DEPTH;
         n_cmp++;
         if (bus.o_AluReady !== er) begin
            n_bad++;
            $display("FAIL %s_alu_ready c%0d: got %b want %b", tag, c, bus.o_AluReady, er);
         end
         er = m_ld.size() < DEPTH;
         n_cmp++;
         if (bus.o_LdReady !== er) begin
            n_bad++;
            $display("FAIL %s_ld_ready c%0d: got %b want %b", tag, c, bus.o_LdReady, er);
         end
         if (!bus.o_LdReady) ld_low++;
         tick();
         n_cmp++;
         if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData} !== {exp_we, exp_addr, exp_data}) begin
            n_bad++;
            $display("FAIL %s_wr c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", tag, c,
                     bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, exp_we, exp_addr, exp_data);
         end
         n_cmp++;
         if (bus.o_Pending !== exp_pend) begin
            n_bad++;
            $display("FAIL %s_pending c%0d: got %h want %h", tag, c, bus.o_Pending, exp_pend);
         end
         n_cmp++;
         if (bus.o_Idle !== exp_idle()) begin
            n_bad++;
            $display("FAIL %s_idle c%0d: got %b want %b", tag, c, bus.o_Idle, exp_idle());
         end
      end
   endtask

   task automatic test_reset();
      drive_idle();
      bus.i_AluAddr = '0; bus.i_AluData = '0;
      bus.i_LdAddr  = '0; bus.i_LdData  = '0;
      bus.i_IssueAddr = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData} !== '0) begin
         n_bad++;
         $display("FAIL reset_wr: got we=%b a=%0d d=%h want 0/0/0",
                  bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData);
      end
      n_cmp++;
      if (bus.o_Pending !== '0) begin
         n_bad++; $display("FAIL reset_pending: got %h want 0", bus.o_Pending);
      end
      n_cmp++;
      if ({bus.o_AluReady, bus.o_LdReady, bus.o_Idle} !== 3'b111) begin
         n_bad++;
         $display("FAIL reset_ready_idle: got %b%b%b want 111",
                  bus.o_AluReady, bus.o_LdReady, bus.o_Idle);
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      bus.i_AluValid = 1'b1; bus.i_AluAddr = 5'd30; bus.i_AluData = 32'd10;
      tick();
      bus.i_AluValid = 1'b0;
      n_cmp++;
      if (bus.o_WrEnable !== 1'b0) begin
         n_bad++; $display("FAIL single_early: got we=%b want 0", bus.o_WrEnable);
      end
      tick();
      n_cmp++;
      if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData} !== {1'b1, 5'd30, 32'd10}) begin
         n_bad++;
         $display("FAIL single_commit: got we=%b a=%0d d=%0d want 1/30/10",
                  bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData);
      end
      n_cmp++;
      if (bus.o_Idle !== 1'b0) begin
         n_bad++; $display("FAIL single_busy: got idle=%b want 0", bus.o_Idle);
      end
      tick();
      n_cmp++;
      if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, bus.o_Idle} !==
          {1'b0, 5'd30, 32'd10, 1'b1}) begin
         n_bad++;
         $display("FAIL single_after: got we=%b a=%0d d=%0d idle=%b want 0/30/10/1",
                  bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, bus.o_Idle);
      end
   endtask

   task automatic test_pending();
      bus.i_IssueValid = 1'b1; bus.i_IssueAddr = 5'd31;
      tick();
      bus.i_IssueValid = 1'b0;
      n_cmp++;
      if (bus.o_Pending[31] !== 1'b1) begin
         n_bad++; $display("FAIL pend_set: got %b want 1", bus.o_Pending[31]);
      end
      bus.i_LdValid = 1'b1; bus.i_LdAddr = 5'd31; bus.i_LdData = 32'd15;
      tick();
      bus.i_LdValid = 1'b0;
      n_cmp++;
      if (bus.o_Pending[31] !== 1'b1) begin
         n_bad++; $display("FAIL pend_hold: got %b want 1", bus.o_Pending[31]);
      end
      tick();
      n_cmp++;
      if ({bus.o_Pending[31], bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData} !==
          {1'b0, 1'b1, 5'd31, 32'd15}) begin
         n_bad++;
         $display("FAIL pend_clear: got p=%b we=%b a=%0d d=%0d want 0/1/31/15",
                  bus.o_Pending[31], bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData);
      end
      bus.i_LdValid = 1'b1;
      tick();
      bus.i_LdValid = 1'b0;
      bus.i_IssueValid = 1'b1; bus.i_IssueAddr = 5'd31;
      tick();
      bus.i_IssueValid = 1'b0;
      n_cmp++;
      if ({bus.o_Pending[31], bus.o_WrEnable} !== 2'b11) begin
         n_bad++;
         $display("FAIL pend_set_wins: got p=%b we=%b want 1/1",
                  bus.o_Pending[31], bus.o_WrEnable);
      end
      tick();
      n_cmp++;
      if (bus.o_Pending !== exp_pend) begin
         n_bad++; $display("FAIL pend_model: got %h want %h", bus.o_Pending, exp_pend);
      end
   endtask

   task automatic test_dual();
      int na = 0, nl = 0, commits = 0;
      logic [31:0] want;
      for (int c = 0; c < 24; c++) begin
         bus.i_AluValid = na < 8;
         bus.i_AluAddr  = 5'(na);
         bus.i_AluData  = 32'h100 + 32'(na);
         bus.i_LdValid  = nl < 8;
         bus.i_LdAddr   = 5'(16 + nl);
         bus.i_LdData   = 32'h200 + 32'(nl);
         tick();
         if (acc_alu) na++;
         if (acc_ld) nl++;
         n_cmp++;
         if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData} !== {exp_we, exp_addr, exp_data}) begin
            n_bad++;
            $display("FAIL dual_wr c%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", c,
                     bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, exp_we, exp_addr, exp_data);
         end
         if (bus.o_WrEnable === 1'b1) begin
            want = (commits % 2 == 0) ? 32'h100 + 32'(commits / 2)
                                      : 32'h200 + 32'(commits / 2);
            n_cmp++;
            if (bus.o_WrData !== want) begin
               n_bad++;
               $display("FAIL dual_order #%0d: got %h want %h", commits, bus.o_WrData, want);
            end
            commits++;
         end
      end
      drive_idle();
      n_cmp++;
      if (commits != 16) begin
         n_bad++; $display("FAIL dual_count: got %0d want 16", commits);
      end
   endtask

   task automatic test_ld_backpressure();
      drive_idle();
      ld_low = 0;
      run_traffic(12, 100, 100, 0, "ldbp");
      n_cmp++;
      if (ld_low == 0) begin
         n_bad++; $display("FAIL ldbp_ready_drop: got 0 low cycles want >0");
      end
   endtask

   task automatic test_full_stream();
      run_traffic(10, 100, 100, 0, "full");
      run_traffic(20, 0, 0, 0, "drain");
   endtask

   task automatic test_async_reset();
      bus.i_IssueValid = 1'b1; bus.i_IssueAddr = 5'd7;
      for (int i = 0; i < 3; i++) begin
         bus.i_AluValid = 1'b1; bus.i_AluAddr = 5'(i); bus.i_AluData = $urandom;
         bus.i_LdValid  = 1'b1; bus.i_LdAddr  = 5'(8 + i); bus.i_LdData = $urandom;
         tick();
      end
      drive_idle();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, bus.o_Pending} !== '0) begin
         n_bad++;
         $display("FAIL areset_out: got we=%b a=%0d d=%h p=%h want all 0",
                  bus.o_WrEnable, bus.o_WrAddr, bus.o_WrData, bus.o_Pending);
      end
      n_cmp++;
      if ({bus.o_AluReady, bus.o_LdReady, bus.o_Idle} !== 3'b111) begin
         n_bad++;
         $display("FAIL areset_flags: got %b%b%b want 111",
                  bus.o_AluReady, bus.o_LdReady, bus.o_Idle);
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if ({bus.o_WrEnable, bus.o_Idle} !== 2'b01) begin
            n_bad++;
            $display("FAIL areset_quiet c%0d: got we=%b idle=%b want 0/1",
                     i, bus.o_WrEnable, bus.o_Idle);
         end
      end
   endtask

   task automatic test_random();
      run_traffic(300, 60, 50, 30, "rand");
      run_traffic(20, 0, 0, 0, "rdrain");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_pending();
      test_dual();
      test_ld_backpressure();
      test_full_stream();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
